// File: rtl/pc_regfile_if.sv
// pc_regfile_if
// Bundles the sequencer/datapath-facing signals of pc_regfile_unit.
//   slave  : the PC/register-file unit (consumes controls, drives results)
//   master : the instruction sequencer / datapath (drives controls)
// Controls : stall, pc_inc, pc_load, call, ret, pc_load_val,
//            we, waddr, wdata, raddr_a, raddr_b
// Results  : rdata_a, rdata_b, pc_out, addr_reg,
//            stack_full, stack_empty, stack_err
interface pc_regfile_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int NREGS  = 8
);
    localparam int AW = $clog2(NREGS);

    logic              stall;
    logic              pc_inc;
    logic              pc_load;
    logic              call;
    logic              ret;
    logic [PC_W-1:0]   pc_load_val;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
    logic [AW-1:0]     raddr_a;
    logic [AW-1:0]     raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [PC_W-1:0]   pc_out;
    logic [PC_W-1:0]   addr_reg;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    modport slave (
        input  stall, pc_inc, pc_load, call, ret, pc_load_val,
        input  we, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b, pc_out, addr_reg,
        output stack_full, stack_empty, stack_err
    );

    modport master (
        output stall, pc_inc, pc_load, call, ret, pc_load_val,
        output we, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b, pc_out, addr_reg,
        input  stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/pc_regfile_unit.sv
// pc_regfile_unit
// Program counter with increment / load / stall and a hardware call/return
// stack, plus an NREGS x DATA_W register file with two combinational read
// ports, one write port and write-to-read bypass. addr_reg is the fetch
// address to program memory: the PC value one cycle late.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : pc_regfile_if.slave (controls in, PC/stack/register data out)
module pc_regfile_unit #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 8,
    parameter int NREGS       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    pc_regfile_if.slave bus
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int AW   = $clog2(NREGS);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   addr_q, addr_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [PC_W-1:0]   stack_q [STACK_DEPTH];

    logic              push;
    logic [PC_W-1:0]   pc_plus1;
    logic [SI_W-1:0]   push_idx, pop_idx;
    logic              full, empty;

    // sp_q counts valid entries: the next free slot is sp_q, the top is sp_q-1.
    assign full     = (sp_q == SP_W'(STACK_DEPTH));
    assign empty    = (sp_q == '0);
    assign push_idx = SI_W'(sp_q);
    assign pop_idx  = SI_W'(sp_q - SP_W'(1));
    assign pc_plus1 = pc_q + PC_W'(1);

    // PC / stack control, priority stall > ret > call > pc_load > pc_inc.
    always_comb begin
        pc_d   = pc_q;
        addr_d = addr_q;
        sp_d   = sp_q;
        err_d  = err_q;
        push   = 1'b0;
        if (!bus.stall) begin
            addr_d = pc_q;
            if (bus.ret) begin
                if (!empty) begin
                    pc_d = stack_q[pop_idx];
                    sp_d = sp_q - SP_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else if (bus.call) begin
                if (!full) begin
                    push = 1'b1;
                    pc_d = bus.pc_load_val;
                    sp_d = sp_q + SP_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else if (bus.pc_load) begin
                pc_d = bus.pc_load_val;
            end else if (bus.pc_inc) begin
                pc_d = pc_plus1;
            end
        end
    end

    // Register file writes are independent of stall.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (bus.we && (bus.waddr == AW'(i)))
                regs_d[i] = bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            addr_q <= '0;
            sp_q   <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            addr_q <= addr_d;
            sp_q   <= sp_d;
            err_q  <= err_d;
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= regs_d[i];
        end
    end

    // Stack contents are not reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (push && !rst)
            stack_q[push_idx] <= pc_plus1;
    end

    // A same-cycle write to the addressed entry is forwarded to the reader.
    assign bus.rdata_a = (bus.we && (bus.raddr_a == bus.waddr)) ? bus.wdata
                                                                : regs_q[bus.raddr_a];
    assign bus.rdata_b = (bus.we && (bus.raddr_b == bus.waddr)) ? bus.wdata
                                                                : regs_q[bus.raddr_b];

    assign bus.pc_out      = pc_q;
    assign bus.addr_reg    = addr_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_pc_regfile_unit.sv
// Testbench for pc_regfile_unit (default parameters: 8-bit data, 8-bit PC,
// 8 registers, 4-deep stack). A behavioural model (queue-based stack, plain
// array register file) is stepped on each rising edge and compared with the
// DUT 1 time unit later; directed scenarios add literal expectations.
module tb_pc_regfile_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_regfile_if #(.DATA_W(8), .PC_W(8), .NREGS(8)) bus ();

    pc_regfile_unit #(.DATA_W(8), .PC_W(8), .NREGS(8), .STACK_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state
    logic [7:0] m_pc, m_addr;
    logic       m_err;
    logic [7:0] m_stk[$];
    logic [7:0] m_regs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        m_pc   = 8'h00;
        m_addr = 8'h00;
        m_err  = 1'b0;
        m_stk.delete();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    endtask

    task automatic mdl_step();
        if (rst) begin
            mdl_reset();
            return;
        end
        if (bus.we) m_regs[bus.waddr] = bus.wdata;
        if (bus.stall) return;
        m_addr = m_pc;
        if (bus.ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_err = 1'b1;
        end else if (bus.call) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(m_pc + 8'd1);
                m_pc = bus.pc_load_val;
            end else begin
                m_err = 1'b1;
            end
        end else if (bus.pc_load) begin
            m_pc = bus.pc_load_val;
        end else if (bus.pc_inc) begin
            m_pc = m_pc + 8'd1;
        end
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] ra);
        if (bus.we && ra == bus.waddr) return bus.wdata;
        return m_regs[ra];
    endfunction

    // Advance one clock: model steps at the edge, bench returns on the falling edge.
    task automatic tick();
        @(posedge clk);
        mdl_step();
        @(negedge clk);
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("pc_out",      bus.pc_out,      m_pc);
            chk("addr_reg",    bus.addr_reg,    m_addr);
            chk("stack_full",  bus.stack_full,  m_stk.size() == DEPTH);
            chk("stack_empty", bus.stack_empty, m_stk.size() == 0);
            chk("stack_err",   bus.stack_err,   m_err);
            chk("rdata_a",     bus.rdata_a,     m_read(bus.raddr_a));
            chk("rdata_b",     bus.rdata_b,     m_read(bus.raddr_b));
        end
    end

    initial begin
        bus.stall = 0; bus.pc_inc = 0; bus.pc_load = 0; bus.call = 0; bus.ret = 0;
        bus.pc_load_val = 8'h00; bus.we = 0; bus.waddr = 3'd0; bus.wdata = 8'h00;
        bus.raddr_a = 3'd0; bus.raddr_b = 3'd0;
        mdl_reset();
        tick(); tick();
        chk("reset pc_out",      bus.pc_out, 8'h00);
        chk("reset addr_reg",    bus.addr_reg, 8'h00);
        chk("reset stack_empty", bus.stack_empty, 1'b1);
        chk("reset stack_full",  bus.stack_full, 1'b0);
        chk("reset stack_err",   bus.stack_err, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: increment sequence
        bus.pc_inc = 1;
        tick(); chk("t1 pc1", bus.pc_out, 8'h01); chk("t1 addr1", bus.addr_reg, 8'h00);
        tick(); chk("t1 pc2", bus.pc_out, 8'h02); chk("t1 addr2", bus.addr_reg, 8'h01);
        tick(); chk("t1 pc3", bus.pc_out, 8'h03); chk("t1 addr3", bus.addr_reg, 8'h02);

        // 2: wrap FF -> 00
        bus.pc_inc = 0; bus.pc_load = 1; bus.pc_load_val = 8'hFF;
        tick(); chk("t2 load FF", bus.pc_out, 8'hFF);
        bus.pc_load = 0; bus.pc_inc = 1;
        tick(); chk("t2 wrap pc", bus.pc_out, 8'h00); chk("t2 wrap addr", bus.addr_reg, 8'hFF);

        // 3: call / ret
        bus.pc_inc = 0; bus.pc_load = 1; bus.pc_load_val = 8'h10;
        tick();
        bus.pc_load = 0; bus.call = 1; bus.pc_load_val = 8'h40;
        tick(); chk("t3 call pc", bus.pc_out, 8'h40); chk("t3 nonempty", bus.stack_empty, 1'b0);
        bus.call = 0; bus.ret = 1;
        tick(); chk("t3 ret pc", bus.pc_out, 8'h11); chk("t3 empty", bus.stack_empty, 1'b1);

        // 4: fill stack, overflow, drain, underflow
        bus.ret = 0; bus.call = 1;
        bus.pc_load_val = 8'h20; tick();
        bus.pc_load_val = 8'h30; tick();
        bus.pc_load_val = 8'h50; tick();
        bus.pc_load_val = 8'h60; tick();
        chk("t4 full", bus.stack_full, 1'b1);
        chk("t4 err before overflow", bus.stack_err, 1'b0);
        bus.pc_load_val = 8'h80; tick();
        chk("t4 overflow pc", bus.pc_out, 8'h60);
        chk("t4 overflow full", bus.stack_full, 1'b1);
        chk("t4 overflow err", bus.stack_err, 1'b1);
        bus.call = 0; bus.ret = 1;
        tick(); chk("t4 pop1", bus.pc_out, 8'h51);
        tick(); chk("t4 pop2", bus.pc_out, 8'h31);
        tick(); chk("t4 pop3", bus.pc_out, 8'h21);
        tick(); chk("t4 pop4", bus.pc_out, 8'h12);
        tick(); chk("t4 underflow pc", bus.pc_out, 8'h12); chk("t4 underflow err", bus.stack_err, 1'b1);

        // 5: write with bypass
        bus.ret = 0;
        bus.we = 1; bus.waddr = 3'd3; bus.wdata = 8'hA5; bus.raddr_a = 3'd3; bus.raddr_b = 3'd2;
        #1;
        chk("t5 bypass a", bus.rdata_a, 8'hA5);
        chk("t5 other b",  bus.rdata_b, 8'h00);
        tick();
        bus.we = 0;
        #1;
        chk("t5 stored a", bus.rdata_a, 8'hA5);
        bus.raddr_b = 3'd3;
        #1;
        chk("t5 stored b", bus.rdata_b, 8'hA5);

        // 6: stall with concurrent write, then asynchronous reset
        bus.call = 1; bus.pc_load_val = 8'h70;
        tick(); chk("t6 call pc", bus.pc_out, 8'h70);
        bus.stall = 1; bus.pc_inc = 1; bus.pc_load_val = 8'h90;
        bus.we = 1; bus.waddr = 3'd5; bus.wdata = 8'h3C; bus.raddr_a = 3'd5;
        tick();
        chk("t6 stall pc",    bus.pc_out, 8'h70);
        chk("t6 stall addr",  bus.addr_reg, 8'h12);
        chk("t6 stall empty", bus.stack_empty, 1'b0);
        bus.we = 0;
        #1;
        chk("t6 write landed", bus.rdata_a, 8'h3C);
        bus.stall = 0; bus.call = 0; bus.pc_inc = 0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t6 async pc",    bus.pc_out, 8'h00);
        chk("t6 async addr",  bus.addr_reg, 8'h00);
        chk("t6 async empty", bus.stack_empty, 1'b1);
        chk("t6 async full",  bus.stack_full, 1'b0);
        chk("t6 async err",   bus.stack_err, 1'b0);
        chk("t6 async reg5",  bus.rdata_a, 8'h00);
        mdl_reset();
        tick(); tick();
        rst = 1'b0;

        // Post-reset activity
        bus.pc_inc = 1;
        tick(); tick();
        chk("post pc", bus.pc_out, 8'h02);
        bus.pc_inc = 0; bus.pc_load = 1; bus.pc_load_val = 8'hC3; bus.pc_inc = 1;
        tick(); chk("load over inc", bus.pc_out, 8'hC3);
        bus.pc_load = 0; bus.pc_inc = 0;
        tick();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_regfile_unit.md
Name: pc_regfile_unit

Overview:
Parametrised successor to the CPU's basic PC/working-register block. Holds a program counter with increment, load, stall and a hardware call/return stack. Also holds a multi-entry register file with two combinational read ports, one write port and write-to-read bypass. Sits between the instruction sequencer and the datapath. Drives the registered fetch address to program memory.

Parameters:
DATA_W, 8, register file word width (>=1)
PC_W, 8, program counter / fetch address width (>=2)
NREGS, 8, register file entries (power of 2, >=2)
STACK_DEPTH, 4, call stack entries (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  freeze PC, addr_reg and stack this cycle
pc_inc  in  1  advance PC by 1
pc_load  in  1  load PC from pc_load_val (jump)
call  in  1  push return address, jump to pc_load_val
ret  in  1  pop stack into PC
pc_load_val  in  PC_W  jump/call target
we  in  1  register file write enable
waddr  in  $clog2(NREGS)  write index
wdata  in  DATA_W  write data
raddr_a  in  $clog2(NREGS)  read port A index
raddr_b  in  $clog2(NREGS)  read port B index
rdata_a  out  DATA_W  read port A data, combinational
rdata_b  out  DATA_W  read port B data, combinational
pc_out  out  PC_W  current PC
addr_reg  out  PC_W  fetch address, PC delayed one cycle
stack_full  out  1  stack holds STACK_DEPTH entries
stack_empty  out  1  stack holds 0 entries
stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. While rst is high:
  - pc_out=0, addr_reg=0, all register entries=0.
  - Stack pointer=0, so stack_empty=1 and stack_full=0.
  - stack_err=0.
- Reset asserted mid-operation aborts everything at once. No pending push, pop or write survives.
- PC control priority per cycle: stall > ret > call > pc_load > pc_inc > hold.
  - stall=1: PC, addr_reg, stack and stack_err all hold. Register file writes still occur.
  - ret, stack not empty: PC <= top entry; pointer decrements.
  - ret, stack empty: PC holds; stack_err <= 1.
  - call, stack not full: push (PC+1) mod 2^PC_W; PC <= pc_load_val.
  - call, stack full: no push, PC holds, stack_err <= 1.
  - pc_load: PC <= pc_load_val.
  - pc_inc: PC <= PC+1, wrapping 2^PC_W-1 -> 0.
- addr_reg: every non-stalled cycle, addr_reg <= the PC value before the update. This is one cycle of latency behind PC.
- stack_full and stack_empty decode the stack pointer combinationally. stack_err is cleared only by rst.
- Register file:
  - Write on the rising edge when we=1.
  - Reads are combinational from the array.
  - Bypass: if we=1 and raddr_x==waddr, rdata_x returns wdata in the same cycle. This applies to both ports independently.
  - No hard-wired zero register; every entry is writable.
- Return address width is PC_W. Stack storage is not reset-cleared beyond the pointer; contents are don't-care when empty.

Test Plan:
1. Reset, then pc_inc=1 for 3 cycles. Required: pc_out 0->1->2->3; addr_reg trails by one cycle, 0,0,1,2.
2. PC at 8'hFF with pc_inc=1. Required: pc_out=8'h00, and addr_reg=8'hFF on the next edge.
3. pc_out=8'h10, call with pc_load_val=8'h40. Required: pc_out=8'h40, stack_empty=0. Then ret: pc_out=8'h11, stack_empty=1.
4. 4 calls (reach full), then a 5th call with pc_load_val=8'h80. Required: pc_out unchanged, stack_full=1, stack_err=1. Then ret on an empty stack after 4 pops: stack_err stays 1, pc_out holds.
5. we=1, waddr=3, wdata=8'hA5, raddr_a=3, raddr_b=2. Required: rdata_a=8'hA5 same cycle (bypass), rdata_b=0. Next cycle with we=0: rdata_a=8'hA5.
6. stall=1 together with pc_inc=1 and call=1. Required: pc_out, addr_reg and stack unchanged. A concurrent register write to entry 5 (8'h3C) still lands. Then assert rst mid-cycle: all outputs return to reset values immediately, without waiting for a clock edge.
